// File: rtl/preproc_mc.sv
// Multi-channel log-compression pre-processor: magnitude, floor, shift, saturate, channel tag.
// Optional frame clamp statistics when PREPROC_CLAMP_STATS_EN is defined.
module preproc_mc #(
  parameter int DATA_WIDTH    = 16,
  parameter int NORM_WIDTH    = 16,
  parameter int MIN_THRESHOLD = 1,
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int SHIFT_W       = 4,
  parameter int SIGNED_IN     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [SHIFT_W-1:0]    cfg_shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NORM_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_last
`ifdef PREPROC_CLAMP_STATS_EN
  ,
  output logic [15:0]           clamp_cnt,
  output logic [0:0]            clamp_cnt_vld
`endif
);

  localparam logic [DATA_WIDTH-1:0] MIN_D   = DATA_WIDTH'(MIN_THRESHOLD);
  localparam logic [NORM_WIDTH-1:0] MIN_N   = NORM_WIDTH'(MIN_THRESHOLD);
  localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH:0]   MAXV    = (DATA_WIDTH+1)'((64'd1 << NORM_WIDTH) - 64'd1);
  localparam logic [CH_W-1:0]       CH_MAX  = CH_W'(NUM_CH-1);

  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_val;
  logic [SHIFT_W-1:0]    s1_shift;
  logic                  s1_last;
  logic [CH_W-1:0]       s1_ch, ch_cnt;
  logic                  s2_adv, s1_adv, accept;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid && !reset;

  // S1 combinational front end
  logic [DATA_WIDTH-1:0] mag, flo;
  logic                  clamp;
  always_comb begin
    mag = in_data;
    if (SIGNED_IN != 0 && in_data[DATA_WIDTH-1]) begin
      mag = ~in_data + DATA_WIDTH'(1);
      // only the most-negative value negates to itself
      if (mag[DATA_WIDTH-1]) mag = POS_MAX;
    end
    clamp = mag < MIN_D;
    flo   = clamp ? MIN_D : mag;
  end

  // S2 combinational back end: shift, saturate, re-floor
  logic [DATA_WIDTH-1:0] shifted;
  logic [NORM_WIDTH-1:0] norm;
  always_comb begin
    shifted = s1_val >> s1_shift;
    norm    = ({1'b0, shifted} > MAXV) ? {NORM_WIDTH{1'b1}} : shifted[NORM_WIDTH-1:0];
    if (norm < MIN_N) norm = MIN_N;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_shift <= '0;
      s1_last  <= 1'b0;
      s1_ch    <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ch   <= '0;
      out_last <= 1'b0;
      ch_cnt   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_val   <= flo;
          s1_shift <= cfg_shift;
          s1_last  <= in_last;
          s1_ch    <= ch_cnt;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= norm;
          out_ch   <= s1_ch;
          out_last <= s1_last;
        end
      end
      if (accept)
        ch_cnt <= (in_last || ch_cnt == CH_MAX) ? '0 : ch_cnt + CH_W'(1);
    end
  end

`ifdef PREPROC_CLAMP_STATS_EN
  logic [15:0] clamp_run, run_nx;
  assign run_nx = (clamp && clamp_run != 16'hFFFF) ? clamp_run + 16'd1 : clamp_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      clamp_run     <= '0;
      clamp_cnt     <= '0;
      clamp_cnt_vld <= '0;
    end else begin
      clamp_cnt_vld <= '0;
      if (accept) begin
        if (in_last) begin
          clamp_cnt     <= run_nx;
          clamp_cnt_vld <= 1'b1;
          clamp_run     <= '0;
        end else begin
          clamp_run <= run_nx;
        end
      end
    end
  end
`endif

endmodule
